// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined immediate extender for the decode stage. This block takes a raw
// field container and a per-transaction field MSB, and then extends the field
// in one of four modes:
//   00 zero-extend
//   01 sign-extend
//   10 sign-extend then shift left by one (branch offsets; flags overflow)
//   11 upper placement (field MSB moved to OUT_W-1, low bits zero)
// Results are registered behind a valid/ready handshake. The storage is an
// output register (OR) plus one skid register (SK). This keeps in_ready
// purely registered, with no combinational path from out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of OR and SK (highest priority)
//   in_valid   input transaction valid
//   in_ready   block can accept (registered: ~SK.valid)
//   in_data    raw field container, bits above in_msb ignored
//   in_msb     zero-indexed field MSB, clamped to IN_W-1
//   in_mode    extension mode
//   out_valid  OR holds a result
//   out_ready  consumer accepts
//   out_data   extended result
//   out_ovf    mode 10 lost a significant bit
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int MSB_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [MSB_W-1:0] in_msb,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  // ---------------------------------------------------------------------------
  // Extension datapath (combinational)
  // ---------------------------------------------------------------------------
  logic [MSB_W-1:0] msb_eff;
  logic [OUT_W-1:0] data_ext;   // in_data zero-padded to OUT_W
  logic [OUT_W-1:0] field_ext;  // field with bits above msb cleared
  logic [OUT_W-1:0] sext;       // field sign-extended from msb
  logic [OUT_W-1:0] res_data;
  logic             res_ovf;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    msb_eff   = in_msb;
    data_ext  = '0;
    field_ext = '0;
    sext      = '0;
    res_data  = '0;
    res_ovf   = 1'b0;

    // This comparison only matters when IN_W is not a power of two.
    if (int'(in_msb) > IN_W - 1) begin
      msb_eff = MSB_W'(IN_W - 1);
    end

    data_ext[IN_W-1:0] = in_data;

    for (int i = 0; i < OUT_W; i++) begin
      if (i <= int'(msb_eff)) begin
        field_ext[i] = data_ext[i];
        sext[i]      = data_ext[i];
      end else begin
        field_ext[i] = 1'b0;
        sext[i]      = data_ext[msb_eff];
      end
    end

    case (in_mode)
      2'b00: res_data = field_ext;
      2'b01: res_data = sext;
      2'b10: begin
        res_data = {sext[OUT_W-2:0], 1'b0};
        // The doubled value no longer fits when the two top bits disagree.
        res_ovf  = sext[OUT_W-1] ^ sext[OUT_W-2];
      end
      default: res_data = field_ext << (OUT_W - 1 - int'(msb_eff));
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  logic             or_valid_q, or_valid_d;
  logic [OUT_W-1:0] or_data_q,  or_data_d;
  logic             or_ovf_q,   or_ovf_d;
  logic             sk_valid_q, sk_valid_d;
  logic [OUT_W-1:0] sk_data_q,  sk_data_d;
  logic             sk_ovf_q,   sk_ovf_d;

  logic accept;
  logic out_hs;

  assign in_ready  = ~sk_valid_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_ovf   = or_ovf_q;

  assign accept = in_valid & ~sk_valid_q;
  assign out_hs = or_valid_q & out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_ovf_d   = or_ovf_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_ovf_d   = sk_ovf_q;

    if (flush) begin
      // The payload is left as is. Only the valid bits matter after a squash.
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (out_hs && sk_valid_q) begin
      // in_ready is low whenever SK is full, so no accept can coincide here.
      or_data_d  = sk_data_q;
      or_ovf_d   = sk_ovf_q;
      sk_valid_d = 1'b0;
    end else if (accept) begin
      if (!or_valid_q || out_hs) begin
        // OR is empty or is being consumed this edge. Replace it with no bubble.
        or_valid_d = 1'b1;
        or_data_d  = res_data;
        or_ovf_d   = res_ovf;
      end else begin
        sk_valid_d = 1'b1;
        sk_data_d  = res_data;
        sk_ovf_d   = res_ovf;
      end
    end else if (out_hs) begin
      or_valid_d = 1'b0;
    end
  end

  // NOTE: the data registers are reset along with the valid bits, because
  // out_data and out_ovf are required to read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_ovf_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_ovf_q   <= or_ovf_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_ovf_q   <= sk_ovf_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//
// Directed bench for imm_extend_pipe. A queue-based reference model tracks the
// results held by the block, and a negedge monitor compares against it every
// cycle. Directed sections pin literal expectations: the mode vectors,
// backpressure ordering and timing, flush, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int MSB_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [MSB_W-1:0] in_msb = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] data;
  } res_t;

  res_t model_q[$];

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_W(MSB_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_msb    (in_msb),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // The reference extender works on integer values. The field is taken as an
  // unsigned or two's-complement number, and the result is truncated to OUT_W.
  function automatic res_t model(input logic [IN_W-1:0] d, input int msb_in,
                                 input logic [1:0] mode);
    int     msb;
    longint field, sv, r, lim;
    res_t   res;
    msb   = (msb_in > IN_W - 1) ? IN_W - 1 : msb_in;
    field = longint'(d) & ((longint'(1) << (msb + 1)) - 1);
    sv    = field;
    if (((field >> msb) & 1) == 1) sv = field - (longint'(1) << (msb + 1));
    lim     = longint'(1) << (OUT_W - 1);
    res.ovf = 1'b0;
    case (mode)
      2'b00:   r = field;
      2'b01:   r = sv;
      2'b10: begin
        r       = sv * 2;
        res.ovf = (r >= lim) || (r < -lim);
      end
      default: r = field << (OUT_W - 1 - msb);
    endcase
    res.data = r[OUT_W-1:0];
    return res;
  endfunction

  always @(negedge rst_n) model_q.delete();

  // Compare the block against the model, then apply the events the coming
  // edge will perform. Inputs change only just after a rising edge.
  always @(negedge clk) begin
    bit hs;
    bit acc;
    if (rst_n) begin
      check("mon_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      check("mon_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        check("mon_out_data", 32'(out_data), 32'(model_q[0].data));
        check("mon_out_ovf", 32'(out_ovf), 32'(model_q[0].ovf));
      end
      hs  = (model_q.size() > 0) && out_ready;
      acc = in_valid && (model_q.size() < 2);
      if (flush) begin
        model_q.delete();
      end else begin
        if (hs) void'(model_q.pop_front());
        if (acc) model_q.push_back(model(in_data, int'(in_msb), in_mode));
      end
    end
  end

  // This task is called just after a rising edge, with the block able to
  // accept and out_ready high.
  task automatic single(input string name, input logic [15:0] d, input logic [3:0] m,
                        input logic [1:0] md, input logic [15:0] exp_d, input logic exp_o);
    in_valid = 1'b1;
    in_data  = d;
    in_msb   = m;
    in_mode  = md;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(exp_d));
    check({name, "_ovf"}, 32'(out_ovf), 32'(exp_o));
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next;
    int got[$];
    int hs_cyc[$];
    int exp_cyc[6];
    exp_cyc = '{1, 6, 7, 8, 9, 10};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Modes 00/01, including junk above the MSB
    single("m01_f8",   16'h00F8, 4'd7, 2'b01, 16'hFFF8, 1'b0);
    single("m00_f8",   16'h00F8, 4'd7, 2'b00, 16'h00F8, 1'b0);
    single("m01_aaf8", 16'hAAF8, 4'd7, 2'b01, 16'hFFF8, 1'b0);
    single("m00_aaf8", 16'hAAF8, 4'd7, 2'b00, 16'h00F8, 1'b0);
    single("m01_msb0", 16'h0001, 4'd0, 2'b01, 16'hFFFF, 1'b0);
    // Mode 10
    single("m10_1ff",  16'h01FF, 4'd8,  2'b10, 16'hFFFE, 1'b0);
    single("m10_4000", 16'h4000, 4'd15, 2'b10, 16'h8000, 1'b1);
    single("m10_3",    16'h0003, 4'd2,  2'b10, 16'h0006, 1'b0);
    single("m10_8000", 16'h8000, 4'd15, 2'b10, 16'h0000, 1'b1);
    // Mode 11
    single("m11_ab",   16'h00AB, 4'd7,  2'b11, 16'hAB00, 1'b0);
    single("m11_5",    16'h0005, 4'd3,  2'b11, 16'h5000, 1'b0);
    single("m11_1234", 16'h1234, 4'd15, 2'b11, 16'h1234, 1'b0);
    idle_cycle();

    // Backpressure: items 1..6 with out_ready low for cycles 2..5
    next = 1;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c < 6);
      in_valid  = (next <= 6);
      in_data   = 16'(next);
      in_msb    = 4'd15;
      in_mode   = 2'b01;
      if (c == 2) check("bp_in_ready_before_skid", 32'(in_ready), 32'd1);
      if (c >= 2 && c < 6) check("bp_stall_data", 32'(out_data), 32'd2);
      if (c >= 3 && c < 6) check("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (c == 7) check("bp_in_ready_back", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        got.push_back(int'(out_data));
        hs_cyc.push_back(c);
      end
      if (in_valid && in_ready) next++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++) begin
      check("bp_order", 32'(got[i]), 32'(i + 1));
      check("bp_cycle", 32'(hs_cyc[i]), 32'(exp_cyc[i]));
    end
    idle_cycle();

    // Flush with both stages full, and input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_msb    = 4'd15;
    in_mode   = 2'b01;
    in_data   = 16'h0011;
    @(posedge clk); #1;
    in_data   = 16'h0022;
    @(posedge clk); #1;
    check("fl_full_in_ready", 32'(in_ready), 32'd0);
    flush   = 1'b1;
    in_data = 16'h0033;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    // Flush while an accept would land in SK
    in_valid = 1'b1;
    in_data  = 16'h0044;
    @(posedge clk); #1;
    flush   = 1'b1;
    in_data = 16'h0055;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl2_out_valid", 32'(out_valid), 32'd0);
    check("fl2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    single("fl_next", 16'h0066, 4'd15, 2'b01, 16'h0066, 1'b0);
    idle_cycle();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h4000;
    in_msb    = 4'd15;
    in_mode   = 2'b10;
    @(posedge clk); #1;
    in_data = 16'h0077;
    in_msb  = 4'd7;
    in_mode = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ar_pre_ovf", 32'(out_ovf), 32'd1);
    check("ar_pre_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data", 32'(out_data), 32'd0);
    check("ar_out_ovf", 32'(out_ovf), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    single("ar_after", 16'h00F8, 4'd7, 2'b01, 16'hFFF8, 1'b0);
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender for the WISC CPU decode stage. It generalises fixed-field sign extension: the field MSB is chosen per transaction, and four extension modes are supported (zero, sign, sign with shift-left-1 for branch offsets, and upper placement for load-high immediates). Results are registered behind a valid/ready handshake with a skid buffer, so decode can stall without combinational ready paths. A synchronous flush supports branch squash.

## Interface
- IN_W, 16, input field container width; legal range 2..OUT_W.
- OUT_W, 16, output width; must be ≥ IN_W.
- MSB_W, $clog2(IN_W), width of the field-MSB select.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- flush  in  1  synchronous squash of all held data.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept; driven directly from a register.
- in_data  in  IN_W  raw field container; bits above in_msb are ignored.
- in_msb  in  MSB_W  zero-indexed MSB of the field; values ≥ IN_W are clamped to IN_W-1.
- in_mode  in  2  00 zero-extend, 01 sign-extend, 10 sign-extend then <<1, 11 upper placement.
- out_valid  out  1  output holds a result.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  extended result.
- out_ovf  out  1  result lost a significant bit; only mode 10 can set it.

## Operation
- Field f = in_data[in_msb:0]. Let ext_s = f sign-extended from bit in_msb to OUT_W.
- Mode 00: f zero-extended to OUT_W.
- Mode 01: ext_s.
- Mode 10: ext_s << 1, filling the LSB with 0. out_ovf = ext_s[OUT_W-1] XOR ext_s[OUT_W-2].
- Mode 11: f << (OUT_W-1-in_msb). The field MSB lands at bit OUT_W-1, and the low bits are 0.
- out_ovf = 0 in modes 00, 01 and 11.
- Storage has two stages:
  - The output register (OR) drives out_data, out_ovf and out_valid.
  - The skid register (SK) holds one extra result.
  - in_ready = ~SK.valid.
- Accept occurs when in_valid & in_ready. Output handshake occurs when out_valid & out_ready.
- On accept:
  - If OR is empty, or OR is handshaking this cycle while SK is empty, the new result goes to OR.
  - Otherwise it goes to SK.
- On an output handshake with SK full, SK moves to OR and SK empties.
- Ordering is strict FIFO. There is no loss and no duplication.
- flush, on a clock edge, clears OR.valid and SK.valid. Any same-cycle accept is discarded. Flush has priority over all other events.
- While out_valid = 1 and out_ready = 0, out_data and out_ovf stay stable.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - in_ready = 1.
  - SK empty.
- Reset asserted mid-stream empties both stages immediately (asynchronously). Operation resumes on the first edge after deassertion.
- Latency: 1 cycle. A result accepted at edge N is visible with out_valid = 1 after edge N.
- Throughput: 1 per cycle while out_ready = 1.
- With out_ready = 0, two items are absorbed (OR then SK). in_ready drops after the edge that fills SK.
- in_ready rises the cycle after the edge where SK drains into OR.
- Simultaneous accept and output handshake with SK empty: OR is replaced in the same edge, with no bubble.
- After flush: out_valid = 0 and in_ready = 1 on the next cycle.

## Test plan
- Modes 00/01, in_data=16'h00F8, in_msb=7: mode 01 gives out_data=16'hFFF8; mode 00 gives 16'h00F8. Each appears one cycle after accept with out_ovf=0. Bits above in_msb set in in_data (16'hAAF8) give identical results.
- Mode 10:
  - 16'h01FF, msb 8 → 16'hFFFE, ovf 0.
  - 16'h4000, msb 15 → 16'h8000, ovf 1.
  - 16'h0003, msb 2 → 16'h0006, ovf 0.
- Mode 11:
  - 16'h00AB, msb 7 → 16'hAB00.
  - 16'h0005, msb 3 → 16'h5000.
  - msb 15, 16'h1234 → 16'h1234.
- Backpressure: stream values 1..6 (mode 01, msb 15) with out_ready low for 4 cycles mid-stream. in_ready deasserts after the second stalled item. The output sequence is exactly 1..6 with out_data stable while stalled, and full rate before and after the stall.
- Flush: fill OR and SK, then pulse flush while in_valid=1. Next cycle out_valid=0 and in_ready=1. The flushed-cycle input never appears, and the next accepted item emerges after 1 cycle.
- Reset: assert rst_n low asynchronously between edges with both stages full. out_valid, out_data and out_ovf go to 0 without waiting for a clock, and in_ready goes to 1. Normal latency holds after release.
